expr_eval: RTL and testbench
============================

Name: expr_eval

Overview:
- Sequencing controller for a single-digit arithmetic expression stream: one ASCII byte per accepted handshake, grammar digit ((+|*) digit)* terminated by "=".
- Validates syntax and evaluates the expression with "*" binding tighter than "+".
- Multiplication runs on a 4-cycle shift-add datapath; back-pressure is applied while it is busy.
- Sits between a byte source and result consumers in the string-processing path.

Parameters:
- WIDTH, 16, result/accumulator width; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous, active-high reset.
- in  input  8  ASCII character.
- in_valid  input  1  in holds a character.
- in_ready  output  1  block can accept a character this cycle; a character is accepted when in_valid & in_ready.
- result  output  WIDTH  value of the last completed expression.
- error  output  1  last completed expression was malformed.
- done  output  1  one-cycle pulse; result and error are valid.

Behaviour:
- Reset (clr high, asynchronous): state START, sum=0, prod=0, pend_mul=0, result=0, error=0, done=0.
  - in_ready=1 in START, so it is high immediately after reset.
  - clr mid-multiply or mid-expression abandons all partial work. No done pulse is produced.
- Registers:
  - sum: accumulated completed "+" terms.
  - prod: current term.
  - pend_mul: the next operand multiplies prod.
  - mcand, mdig[3:0], acc, cnt[1:0]: multiply datapath.
- Digit: "0".."9"; d = in - "0".
- in_ready = 1 in START, OPND, OPR and ERR; 0 in MUL and FIN. It is decoded from state.
- done = (state == FIN). result and error are registered and hold their value until the next FIN.
- START (expecting the first operand):
  - digit: prod<=d, go OPR.
  - "=": go FIN with error=1, result=0.
  - any other character: go ERR.
- OPND (expecting an operand after an operator):
  - digit with pend_mul=0: prod<=d, go OPR.
  - digit with pend_mul=1: mcand<=prod, mdig<=d, acc<=0, cnt<=0, go MUL.
  - "=": go FIN with error=1, result=0.
  - any other character: go ERR.
- OPR (expecting an operator or "="):
  - "+": sum<=sum+prod, pend_mul<=0, go OPND.
  - "*": pend_mul<=1, go OPND.
  - "=": result<=sum+prod, error<=0, go FIN.
  - digit or any other character: go ERR.
- MUL (exactly 4 cycles):
  - Each cycle: if mdig[cnt], acc<=acc+(mcand<<cnt); then cnt<=cnt+1.
  - On the cycle with cnt=3: prod<=final acc, pend_mul<=0, go OPR.
  - Incoming in_valid is ignored. The source must hold the character until in_ready returns.
- ERR: all characters are consumed and discarded until "=". On "=": result<=0, error<=1, go FIN.
- FIN: one cycle with done=1. Then sum<=0, prod<=0, pend_mul<=0, go START.
  - A character presented during FIN is not accepted, because in_ready=0.
- Timing:
  - "=" accepted at edge k: done is high during cycle k+1.
  - Digit after "*" accepted at edge n: in_ready is low for cycles n+1..n+4 and high again in cycle n+5.
- Width rules:
  - Shifts and adds are truncated to WIDTH bits.
  - d is zero-extended.
  - Overflow is not an error.
- in_valid=0 in any accepting state: hold state, no register changes.

Test Plan:
- "3+4*2=" streamed with in_valid held high -> done pulse, result=11, error=0. in_ready is low for exactly 4 cycles after the "2".
- "9*9*9*9=" -> result=6561, error=0. With WIDTH=8, "9*9*9=" -> result=217, error=0.
- Malformed inputs: "12=", "3+=", "=", "+3=" and "3a4=" -> each gives one done pulse with error=1, result=0. In each case the next expression "5=" gives result=5, error=0.
- Gaps: "7*0+1=" with in_valid deasserted for 3 random cycles between characters -> result=1. No character is lost or duplicated across the MUL stall.
- clr asserted asynchronously during the second MUL cycle of "3*7" -> immediately result=0, error=0, done=0, in_ready=1. A following "2+2=" gives result=4.
- Back-to-back expressions "1+1=" "2*3=" -> two done pulses with result 2 then 6. result and error hold steady between the pulses.

Source files
------------

// File: rtl/expr_eval.sv
// Purpose : validates and evaluates single-digit "d((+|*)d)*=" byte streams, '*' binding tighter than '+'.
// Latency : done pulses in the cycle after '=' is accepted; each multiply occupies 4 cycles.
// Backpr. : in_ready drops while the shift-add multiplier runs and during the done cycle.
// Ports   : clk, clr (async, active high); in/in_valid/in_ready byte handshake;
//           result/error hold the last completed expression; done is a one-cycle pulse.
module expr_eval #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             error,
  output logic             done
);

  typedef enum logic [2:0] {START, OPND, OPR, MUL, ERR, FIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sum, prod, mcand, acc, mul_nxt, dig;
  logic [3:0]       mdig;
  logic [1:0]       cnt;
  logic             pend_mul;
  logic             take, is_dig, is_eq, is_plus, is_star;

  assign take    = in_valid & in_ready;
  assign is_dig  = (in >= 8'h30) && (in <= 8'h39);
  assign is_eq   = (in == 8'h3D);
  assign is_plus = (in == 8'h2B);
  assign is_star = (in == 8'h2A);
  // ASCII digits are 0x30..0x39, so the low nibble is the digit value.
  assign dig     = {{(WIDTH-4){1'b0}}, in[3:0]};

  // One shift-add step: partial product for multiplier bit cnt.
  assign mul_nxt = mdig[cnt] ? acc + (mcand << cnt) : acc;

  assign in_ready = (state != MUL) && (state != FIN);
  assign done     = (state == FIN);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= START;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      START, OPND: begin
        if (take) begin
          if (is_dig)     state_nxt = (state == OPND && pend_mul) ? MUL : OPR;
          else if (is_eq) state_nxt = FIN;
          else            state_nxt = ERR;
        end
      end
      OPR: begin
        if (take) begin
          if (is_plus || is_star) state_nxt = OPND;
          else if (is_eq)         state_nxt = FIN;
          else                    state_nxt = ERR;
        end
      end
      MUL:     if (cnt == 2'd3) state_nxt = OPR;
      ERR:     if (take && is_eq) state_nxt = FIN;
      FIN:     state_nxt = START;
      default: state_nxt = START;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sum      <= '0;
      prod     <= '0;
      pend_mul <= 1'b0;
      mcand    <= '0;
      mdig     <= '0;
      acc      <= '0;
      cnt      <= '0;
      result   <= '0;
      error    <= 1'b0;
    end else begin
      case (state)
        START, OPND: begin
          if (take) begin
            if (is_dig) begin
              if (state == OPND && pend_mul) begin
                mcand <= prod;
                mdig  <= in[3:0];
                acc   <= '0;
                cnt   <= '0;
              end else begin
                prod <= dig;
              end
            end else if (is_eq) begin
              // '=' where an operand was expected: malformed.
              result <= '0;
              error  <= 1'b1;
            end
          end
        end
        OPR: begin
          if (take) begin
            if (is_plus) begin
              sum      <= sum + prod;
              pend_mul <= 1'b0;
            end else if (is_star) begin
              pend_mul <= 1'b1;
            end else if (is_eq) begin
              result <= sum + prod;
              error  <= 1'b0;
            end
          end
        end
        MUL: begin
          acc <= mul_nxt;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            prod     <= mul_nxt;
            pend_mul <= 1'b0;
          end
        end
        ERR: begin
          if (take && is_eq) begin
            result <= '0;
            error  <= 1'b1;
          end
        end
        FIN: begin
          sum      <= '0;
          prod     <= '0;
          pend_mul <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboarded bench for expr_eval: one 16-bit and one 8-bit instance share the
// input stream; expected results come from a string-level parser/evaluator.
module tb_expr_eval;

  typedef logic [7:0] ch_t;
  typedef ch_t cq_t[$];
  typedef struct { longint r; bit e; } exp_t;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  in;
  logic        in_valid;
  logic        rdy16, rdy8, err16, err8, done16, done8;
  logic [15:0] res16;
  logic [7:0]  res8;

  int vectors = 0;
  int miscompares = 0;

  exp_t q16[$];
  exp_t q8[$];
  exp_t last16 = '{0, 0};
  exp_t last8  = '{0, 0};

  always #5 clk = ~clk;

  expr_eval #(.WIDTH(16)) dut16 (
    .clk(clk), .clr(clr), .in(in), .in_valid(in_valid), .in_ready(rdy16),
    .result(res16), .error(err16), .done(done16)
  );

  expr_eval #(.WIDTH(8)) dut8 (
    .clk(clk), .clr(clr), .in(in), .in_valid(in_valid), .in_ready(rdy8),
    .result(res8), .error(err8), .done(done8)
  );

  function automatic void check(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic cq_t s2q(input string s);
    cq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(ch_t'(s[i]));
    return q;
  endfunction

  function automatic bit isdig(input ch_t c);
    return (c >= "0") && (c <= "9");
  endfunction

  // Reference: grammar check on the whole string, then sum of products of digits.
  function automatic void model(input cq_t q, input int w, output longint r, output bit e);
    int     n = q.size();
    bit     ok;
    longint mask, sum, prod;
    mask = (longint'(1) << w) - 1;
    ok = (n >= 2) && (n % 2 == 0) && (q[n-1] == "=");
    for (int i = 0; ok && i < n - 1; i++) begin
      if (i % 2 == 0) ok = isdig(q[i]);
      else            ok = (q[i] == "+") || (q[i] == "*");
    end
    if (!ok) begin
      r = 0;
      e = 1'b1;
      return;
    end
    sum  = 0;
    prod = longint'(q[0] - "0");
    for (int i = 1; i < n - 1; i += 2) begin
      if (q[i] == "+") begin
        sum  = (sum + prod) & mask;
        prod = longint'(q[i+1] - "0");
      end else begin
        prod = (prod * longint'(q[i+1] - "0")) & mask;
      end
    end
    r = (sum + prod) & mask;
    e = 1'b0;
  endfunction

  // Present one character after an idle gap; returns 1ns after the accepting edge.
  task automatic send(input ch_t c, input int gap);
    int budget = 0;
    bit got = 1'b0;
    in_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    in = c;
    in_valid = 1'b1;
    while (!got && budget < 50) begin
      @(negedge clk);
      if (rdy16) got = 1'b1;
      @(posedge clk);
      budget++;
    end
    #1;
    in_valid = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: char %0d not accepted, expected within 50 cycles", c);
    end
  endtask

  task automatic send_expr(input cq_t q, input int maxgap, input bit chk_mul);
    exp_t e16, e8;
    model(q, 16, e16.r, e16.e);
    model(q, 8, e8.r, e8.e);
    q16.push_back(e16);
    q8.push_back(e8);
    for (int i = 0; i < q.size(); i++) begin
      send(q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      if (chk_mul && i > 0 && q[i-1] == "*") begin
        for (int k = 0; k < 4; k++) begin
          check("mul_stall_rdy", longint'(rdy16), 0);
          @(posedge clk);
          #1;
        end
        check("mul_release_rdy", longint'(rdy16), 1);
      end
    end
  endtask

  // Monitor: pops on every done pulse, otherwise outputs must hold.
  always @(negedge clk) begin
    if (clr) begin
      last16 = '{0, 0};
      last8  = '{0, 0};
    end else begin
      if (done16) begin
        if (q16.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL done16_unexpected: got done, expected none");
        end else begin
          last16 = q16.pop_front();
          check("result16", longint'(res16), last16.r);
          check("error16", longint'(err16), longint'(last16.e));
        end
      end else begin
        check("hold_result16", longint'(res16), last16.r);
        check("hold_error16", longint'(err16), longint'(last16.e));
      end
      if (done8) begin
        if (q8.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL done8_unexpected: got done, expected none");
        end else begin
          last8 = q8.pop_front();
          check("result8", longint'(res8), last8.r);
          check("error8", longint'(err8), longint'(last8.e));
        end
      end else begin
        check("hold_result8", longint'(res8), last8.r);
      end
    end
  end

  initial begin
    string bad[5] = '{"12=", "3+=", "=", "+3=", "3a4="};
    int    budget;
    cq_t   q;
    clr = 1'b1;
    in = 8'h00;
    in_valid = 1'b0;
    #12;
    check("reset_in_ready", longint'(rdy16), 1);
    check("reset_done", longint'(done16), 0);
    check("reset_result", longint'(res16), 0);
    check("reset_error", longint'(err16), 0);
    #5 clr = 1'b0;
    @(posedge clk);
    #1;

    send_expr(s2q("3+4*2="), 0, 1'b1);
    send_expr(s2q("9*9*9*9="), 0, 1'b0);
    send_expr(s2q("9*9*9="), 0, 1'b0);
    send_expr(s2q("9*9*9*9="), 0, 1'b0);

    // Abort mid-multiply: reset lands in the second MUL cycle.
    send("3", 0);
    send("*", 0);
    send("7", 0);
    @(posedge clk);
    #3 clr = 1'b1;
    #1;
    check("clr_result", longint'(res16), 0);
    check("clr_error", longint'(err16), 0);
    check("clr_done", longint'(done16), 0);
    check("clr_in_ready", longint'(rdy16), 1);
    #20;
    @(negedge clk);
    #2 clr = 1'b0;
    @(posedge clk);
    #1;
    send_expr(s2q("2+2="), 0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      send_expr(s2q(bad[i]), 0, 1'b0);
      send_expr(s2q("5="), 0, 1'b0);
    end

    send_expr(s2q("7*0+1="), 3, 1'b1);
    send_expr(s2q("1+1="), 0, 1'b0);
    send_expr(s2q("2*3="), 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int  nd = int'($urandom_range(1, 5));
      ch_t b;
      q.delete();
      q.push_back(ch_t'(8'h30 + $urandom_range(0, 9)));
      for (int k = 1; k < nd; k++) begin
        q.push_back(($urandom_range(0, 1) == 1) ? ch_t'("+") : ch_t'("*"));
        q.push_back(ch_t'(8'h30 + $urandom_range(0, 9)));
      end
      q.push_back(ch_t'("="));
      if ($urandom_range(0, 3) == 0) begin
        b = ch_t'($urandom_range(0, 255));
        if (b == "=") b = "?";
        q[$urandom_range(0, q.size() - 2)] = b;
      end
      send_expr(q, 2, 1'b0);
    end

    budget = 0;
    while ((q16.size() != 0 || q8.size() != 0) && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    if (q16.size() != 0 || q8.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d/%0d results outstanding, expected 0", q16.size(), q8.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
